// File: rtl/scfifo_pkg.sv
// rtl/scfifo_pkg.sv - sizing and slice-selection helpers shared by FIFO unpackers
package scfifo_pkg;

  // Widest beat index any unpacker instance may use.
  localparam int BEAT_IDX_MAX_W = 16;
  typedef logic [BEAT_IDX_MAX_W-1:0] beat_idx_t;

  // Bits needed to index RATIO beats; never less than one.
  function automatic int clog2_beats(input int ratio);
    int w = 1;
    while ((1 << w) < ratio) w++;
    return w;
  endfunction

  // Bit offset of beat 'idx' inside a word of 'ratio' beats. Out-of-range
  // indices fall back to slot 0 so callers never shift past the word.
  function automatic int unsigned slice_lsb(input beat_idx_t idx, input int unsigned ratio,
                                            input int unsigned out_width, input bit msb_first);
    int unsigned slot;
    if (32'(idx) >= ratio) slot = 0;
    else if (msb_first)    slot = ratio - 1 - 32'(idx);
    else                   slot = 32'(idx);
    return slot * out_width;
  endfunction

endpackage

// File: rtl/scfifo_unpack_slice_mux.sv
// rtl/scfifo_unpack_slice_mux.sv - combinational beat select from a wide word
//   word [IN_WIDTH]  : wide word to slice
//   idx  [IDX_W]     : beat index, 0 = first emitted beat
//   data [OUT_WIDTH] : selected beat
module scfifo_unpack_slice_mux
  import scfifo_pkg::*;
#(
  parameter int  OUT_WIDTH = 8,
  parameter int  RATIO     = 4,
  parameter int  MSB_FIRST = 0,
  localparam int IN_WIDTH  = OUT_WIDTH * RATIO,
  localparam int IDX_W     = clog2_beats(RATIO)
) (
  input  logic [IN_WIDTH-1:0]  word,
  input  logic [IDX_W-1:0]     idx,
  output logic [OUT_WIDTH-1:0] data
);

  assign data = OUT_WIDTH'(word >> slice_lsb(beat_idx_t'(idx), RATIO, OUT_WIDTH, MSB_FIRST != 0));

endmodule

// File: rtl/scfifo_showahead_unpacker.sv
// rtl/scfifo_showahead_unpacker.sv - drains a show-ahead FIFO into RATIO narrow beats per word
//   clock, aclr_n (async, active low), sclr (sync clear, active high)
//   fifo_q/fifo_empty/fifo_rdreq : show-ahead FIFO read side (rdreq combinational)
//   out_data/out_valid/out_last/out_ready : registered beat stream
//   beats_left : beats still to deliver from the held word, 0 when idle
//   starve_cnt : idle-while-ready cycle count, present only with SCFIFO_UNPACK_STARVE_CNT_EN
module scfifo_showahead_unpacker
  import scfifo_pkg::*;
#(
  parameter int  OUT_WIDTH = 8,
  parameter int  RATIO     = 4,
  parameter int  MSB_FIRST = 0,
  localparam int IN_WIDTH  = OUT_WIDTH * RATIO,
  localparam int IDX_W     = clog2_beats(RATIO),
  localparam int BL_W      = IDX_W + 1
) (
  input  logic                 clock,
  input  logic                 aclr_n,
  input  logic                 sclr,
  input  logic [IN_WIDTH-1:0]  fifo_q,
  input  logic                 fifo_empty,
  output logic                 fifo_rdreq,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic [BL_W-1:0]      beats_left
`ifdef SCFIFO_UNPACK_STARVE_CNT_EN
  ,
  output logic [31:0]          starve_cnt
`endif
);

  logic [IN_WIDTH-1:0]  word_reg;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     next_idx;
  logic [OUT_WIDTH-1:0] first_slice;
  logic [OUT_WIDTH-1:0] next_slice;
  logic                 accept;
  logic                 pop;

  assign accept   = out_valid & out_ready;
  assign next_idx = idx + 1'b1;

  // Pop only when nothing is held, or when the last beat leaves this very
  // cycle; the refill then lands on the same edge and no bubble appears.
  assign pop        = ~fifo_empty & ~sclr & (~out_valid | (out_ready & out_last));
  assign fifo_rdreq = pop;

  // First beat comes straight off the FIFO head so it is ready on the pop edge.
  scfifo_unpack_slice_mux #(
    .OUT_WIDTH(OUT_WIDTH), .RATIO(RATIO), .MSB_FIRST(MSB_FIRST)
  ) u_first_mux (
    .word(fifo_q),
    .idx ('0),
    .data(first_slice)
  );

  scfifo_unpack_slice_mux #(
    .OUT_WIDTH(OUT_WIDTH), .RATIO(RATIO), .MSB_FIRST(MSB_FIRST)
  ) u_next_mux (
    .word(word_reg),
    .idx (next_idx),
    .data(next_slice)
  );

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      word_reg   <= '0;
      idx        <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      beats_left <= '0;
    end else if (sclr) begin
      word_reg   <= '0;
      idx        <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      beats_left <= '0;
    end else if (pop) begin
      word_reg   <= fifo_q;
      idx        <= '0;
      out_data   <= first_slice;
      out_valid  <= 1'b1;
      out_last   <= 1'b0;
      beats_left <= BL_W'(RATIO);
    end else if (accept) begin
      if (out_last) begin
        out_valid  <= 1'b0;
        out_last   <= 1'b0;
        beats_left <= '0;
      end else begin
        idx        <= next_idx;
        out_data   <= next_slice;
        out_last   <= (next_idx == IDX_W'(RATIO - 1));
        beats_left <= beats_left - 1'b1;
      end
    end
  end

`ifdef SCFIFO_UNPACK_STARVE_CNT_EN
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      starve_cnt <= '0;
    end else if (sclr) begin
      starve_cnt <= '0;
    end else if (out_ready && !out_valid && !(&starve_cnt)) begin
      starve_cnt <= starve_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_scfifo_showahead_unpacker.sv
// tb/tb_scfifo_showahead_unpacker.sv - self-checking bench for scfifo_showahead_unpacker
module tb_scfifo_showahead_unpacker;

  localparam int OW  = 8;
  localparam int R   = 4;
  localparam int IW  = 32;
  localparam int BLW = 3;
  localparam logic [31:0] WA = 32'h44332211;
  localparam logic [31:0] WB = 32'h88776655;
  localparam logic [31:0] JUNK = 32'hDEADBEEF;

  logic          clock = 1'b0;
  logic          aclr_n = 1'b0;
  logic          sclr = 1'b0;
  logic [IW-1:0] fifo_q = JUNK;
  logic          fifo_empty = 1'b1;
  logic          out_ready = 1'b0;
  logic          fifo_rdreq, out_valid, out_last;
  logic [OW-1:0] out_data;
  logic [BLW-1:0] beats_left;

  logic [IW-1:0] qb = '0;
  logic          emptyb = 1'b1;
  logic          rdb, vb, lb;
  logic [OW-1:0] db;
  logic [BLW-1:0] blb;
`ifdef SCFIFO_UNPACK_STARVE_CNT_EN
  logic [31:0]   starve_cnt, starve_b;
`endif

  always #5 clock = ~clock;

  scfifo_showahead_unpacker #(.OUT_WIDTH(OW), .RATIO(R), .MSB_FIRST(0)) dut (
    .clock(clock), .aclr_n(aclr_n), .sclr(sclr),
    .fifo_q(fifo_q), .fifo_empty(fifo_empty), .fifo_rdreq(fifo_rdreq),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .beats_left(beats_left)
`ifdef SCFIFO_UNPACK_STARVE_CNT_EN
    , .starve_cnt(starve_cnt)
`endif
  );

  scfifo_showahead_unpacker #(.OUT_WIDTH(OW), .RATIO(R), .MSB_FIRST(1)) dut_msb (
    .clock(clock), .aclr_n(aclr_n), .sclr(1'b0),
    .fifo_q(qb), .fifo_empty(emptyb), .fifo_rdreq(rdb),
    .out_data(db), .out_valid(vb), .out_last(lb),
    .out_ready(1'b1), .beats_left(blb)
`ifdef SCFIFO_UNPACK_STARVE_CNT_EN
    , .starve_cnt(starve_b)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference: FIFO contents plus the list of beats still owed from the held word.
  typedef struct { logic [7:0] d; bit l; } beat_t;
  beat_t         mq[$];
  logic [31:0]   fq[$];
  bit            last_rd;

  task automatic refresh_fifo();
    fifo_empty = (fq.size() == 0);
    fifo_q     = fifo_empty ? JUNK : fq[0];
  endtask

  task automatic check_outputs(string tag);
    if (mq.size() > 0) begin
      check({tag, " valid"}, 32'(out_valid), 32'd1);
      check({tag, " data"},  32'(out_data),  32'(mq[0].d));
      check({tag, " last"},  32'(out_last),  32'(mq[0].l));
      check({tag, " beats_left"}, 32'(beats_left), 32'(mq.size()));
    end else begin
      check({tag, " valid"}, 32'(out_valid), 32'd0);
      check({tag, " last"},  32'(out_last),  32'd0);
      check({tag, " beats_left"}, 32'(beats_left), 32'd0);
    end
  endtask

  // Called just after a rising edge with inputs already set for the coming cycle.
  task automatic step(string tag);
    bit held, exp_rd;
    logic [31:0] w;
    refresh_fifo();
    @(negedge clock);
    held   = (mq.size() > 0);
    exp_rd = (fq.size() > 0) && !sclr && (!held || (out_ready && mq[0].l));
    last_rd = fifo_rdreq;
    check({tag, " rdreq"}, 32'(last_rd), 32'(exp_rd));
    w = fifo_q;
    @(posedge clock);
    #1;
    if (last_rd && fq.size() > 0) void'(fq.pop_front());
    if (sclr) mq.delete();
    else begin
      if (held && out_ready) void'(mq.pop_front());
      if (exp_rd)
        for (int k = 0; k < R; k++) mq.push_back('{d: 8'(w >> (8 * k)), l: (k == R - 1)});
    end
    refresh_fifo();
    check_outputs(tag);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    sclr = 1'b0;
    for (int i = 0; i < 40 && (mq.size() > 0 || fq.size() > 0); i++) step("drain");
    check("drain finished", 32'(mq.size() + fq.size()), 32'd0);
  endtask

  typedef struct {
    bit push; logic [31:0] word; bit rdy;
    bit rd; bit v; logic [7:0] d; bit l; logic [2:0] bl;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit push, logic [31:0] word, bit rdy, bit rd, bit v,
                              logic [7:0] d, bit l, logic [2:0] bl);
    vec_t t;
    t.push = push; t.word = word; t.rdy = rdy; t.rd = rd;
    t.v = v; t.d = d; t.l = l; t.bl = bl;
    return t;
  endfunction

  logic [7:0] msb_exp [4];

  initial begin
    // basic single word
    tbl.push_back(mk(1, WA, 1, 1, 1, 8'h11, 0, 4));
    tbl.push_back(mk(0, 0,  1, 0, 1, 8'h22, 0, 3));
    tbl.push_back(mk(0, 0,  1, 0, 1, 8'h33, 0, 2));
    tbl.push_back(mk(0, 0,  1, 0, 1, 8'h44, 1, 1));
    tbl.push_back(mk(0, 0,  1, 0, 0, 8'h00, 0, 0));
    // back-to-back words, second pop on the 0x44 accept
    tbl.push_back(mk(1, WA, 1, 1, 1, 8'h11, 0, 4));
    tbl.push_back(mk(1, WB, 1, 0, 1, 8'h22, 0, 3));
    tbl.push_back(mk(0, 0,  1, 0, 1, 8'h33, 0, 2));
    tbl.push_back(mk(0, 0,  1, 0, 1, 8'h44, 1, 1));
    tbl.push_back(mk(0, 0,  1, 1, 1, 8'h55, 0, 4));
    tbl.push_back(mk(0, 0,  1, 0, 1, 8'h66, 0, 3));
    tbl.push_back(mk(0, 0,  1, 0, 1, 8'h77, 0, 2));
    tbl.push_back(mk(0, 0,  1, 0, 1, 8'h88, 1, 1));
    tbl.push_back(mk(0, 0,  1, 0, 0, 8'h00, 0, 0));
    // backpressure after 0x22 for five cycles, next word waiting
    tbl.push_back(mk(1, WA, 1, 1, 1, 8'h11, 0, 4));
    tbl.push_back(mk(0, 0,  1, 0, 1, 8'h22, 0, 3));
    tbl.push_back(mk(0, 0,  1, 0, 1, 8'h33, 0, 2));
    tbl.push_back(mk(1, WB, 0, 0, 1, 8'h33, 0, 2));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 0, 1, 8'h33, 0, 2));
    tbl.push_back(mk(0, 0,  1, 0, 1, 8'h44, 1, 1));
    tbl.push_back(mk(0, 0,  1, 1, 1, 8'h55, 0, 4));
    tbl.push_back(mk(0, 0,  1, 0, 1, 8'h66, 0, 3));
    tbl.push_back(mk(0, 0,  1, 0, 1, 8'h77, 0, 2));
    tbl.push_back(mk(0, 0,  1, 0, 1, 8'h88, 1, 1));
    // stall on a last beat with a word waiting: no pop until accepted
    tbl.push_back(mk(1, WA, 0, 0, 1, 8'h88, 1, 1));
    tbl.push_back(mk(0, 0,  1, 1, 1, 8'h11, 0, 4));
    tbl.push_back(mk(0, 0,  1, 0, 1, 8'h22, 0, 3));
    tbl.push_back(mk(0, 0,  1, 0, 1, 8'h33, 0, 2));
    tbl.push_back(mk(0, 0,  1, 0, 1, 8'h44, 1, 1));
    tbl.push_back(mk(0, 0,  1, 0, 0, 8'h00, 0, 0));

    // reset state while aclr_n is held low
    #2;
    check("reset valid", 32'(out_valid), 32'd0);
    check("reset last", 32'(out_last), 32'd0);
    check("reset data", 32'(out_data), 32'd0);
    check("reset beats_left", 32'(beats_left), 32'd0);
    check("reset rdreq", 32'(fifo_rdreq), 32'd0);
    @(negedge clock);
    aclr_n = 1'b1;
    @(posedge clock);
    #1;

    // table-driven vectors
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].push) fq.push_back(tbl[i].word);
      out_ready = tbl[i].rdy;
      step("tbl");
      check($sformatf("tbl[%0d] rdreq", i), 32'(last_rd), 32'(tbl[i].rd));
      check($sformatf("tbl[%0d] valid", i), 32'(out_valid), 32'(tbl[i].v));
      check($sformatf("tbl[%0d] last", i), 32'(out_last), 32'(tbl[i].l));
      check($sformatf("tbl[%0d] beats_left", i), 32'(beats_left), 32'(tbl[i].bl));
      if (tbl[i].v) check($sformatf("tbl[%0d] data", i), 32'(out_data), 32'(tbl[i].d));
    end

    // sclr mid-word with another word waiting
    out_ready = 1'b1;
    fq.push_back(WA);
    step("sclr pre");
    step("sclr pre");
    check("sclr pre data", 32'(out_data), 32'h22);
    fq.push_back(WB);
    sclr = 1'b1;
    step("sclr");
    check("sclr rdreq", 32'(last_rd), 32'd0);
    check("sclr valid", 32'(out_valid), 32'd0);
    check("sclr beats_left", 32'(beats_left), 32'd0);
    sclr = 1'b0;
    step("sclr post");
    check("sclr post data", 32'(out_data), 32'h55);
    drain();

    // aclr_n pulse mid-cycle: outputs must clear before the next edge
    fq.push_back(WA);
    step("aclr pre");
    step("aclr pre");
    #1 aclr_n = 1'b0;
    #1;
    check("aclr valid", 32'(out_valid), 32'd0);
    check("aclr last", 32'(out_last), 32'd0);
    check("aclr data", 32'(out_data), 32'd0);
    check("aclr beats_left", 32'(beats_left), 32'd0);
    aclr_n = 1'b1;
    mq.delete();
    step("aclr post");
    step("aclr post");

    // MSB-first ordering on the second instance
    msb_exp = '{8'h44, 8'h33, 8'h22, 8'h11};
    qb = WA;
    emptyb = 1'b0;
    @(negedge clock);
    check("msb rdreq", 32'(rdb), 32'd1);
    @(posedge clock);
    #1;
    emptyb = 1'b1;
    qb = JUNK;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("msb beat%0d valid", k), 32'(vb), 32'd1);
      check($sformatf("msb beat%0d data", k), 32'(db), 32'(msb_exp[k]));
      check($sformatf("msb beat%0d last", k), 32'(lb), 32'(k == 3));
      check($sformatf("msb beat%0d beats_left", k), 32'(blb), 32'(4 - k));
      @(posedge clock);
      #1;
    end
    check("msb idle valid", 32'(vb), 32'd0);

    // randomized traffic against the reference
    for (int c = 0; c < 600; c++) begin
      if (fq.size() < 3 && $urandom_range(0, 2) == 0) fq.push_back($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      sclr = ($urandom_range(0, 49) == 0);
      step("rand");
    end
    drain();

`ifdef SCFIFO_UNPACK_STARVE_CNT_EN
    out_ready = 1'b1;
    sclr = 1'b1;
    step("starve clr");
    check("starve after sclr", starve_cnt, 32'd0);
    sclr = 1'b0;
    repeat (10) step("starve");
    check("starve count", starve_cnt, 32'd10);
    sclr = 1'b1;
    step("starve clr2");
    check("starve cleared", starve_cnt, 32'd0);
    sclr = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/scfifo_showahead_unpacker.md
Name: scfifo_showahead_unpacker

Overview:
- Drain stage placed directly downstream of a show-ahead single-clock FIFO.
- Pops wide words using the FIFO's q/empty/rdreq interface.
- Serialises each word into RATIO narrow beats on a registered valid/ready stream, with a last-beat marker per word.
- Sustains one beat per cycle across word boundaries with no bubbles.

Parameters:
- OUT_WIDTH, 8: width of one output beat.
- RATIO, 4: beats per FIFO word; must be at least 2.
- IN_WIDTH, OUT_WIDTH*RATIO: FIFO word width. Derived; do not override.
- MSB_FIRST, 0: 0 emits bits [OUT_WIDTH-1:0] first; 1 emits the top slice first.

Ports:
- clock  in  1  sole clock.
- aclr_n  in  1  asynchronous active-low reset.
- sclr  in  1  synchronous clear, active high.
- fifo_q  in  IN_WIDTH  show-ahead FIFO head word; valid whenever fifo_empty=0.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rdreq  out  1  pop request to the FIFO; combinational.
- out_data  out  OUT_WIDTH  current beat; registered.
- out_valid  out  1  beat valid; registered.
- out_last  out  1  final beat of the current word; registered.
- out_ready  in  1  downstream accept.
- beats_left  out  log2(RATIO)+1  beats remaining in the held word, including the current beat; 0 when idle.

Behaviour:
- Reset: aclr_n=0 clears out_valid, out_last, out_data, beats_left, word_reg and the beat index immediately. sclr gives the same result at the next edge and takes priority over all other updates.
- State:
  - HELD is true when out_valid=1.
  - word_reg holds IN_WIDTH bits.
  - idx counts 0..RATIO-1.
- Beat accept: a beat is accepted on a cycle where out_valid & out_ready.
- Pop rule: fifo_rdreq = ~fifo_empty & ~sclr & (~out_valid | (out_ready & out_last)).
  - Never pop while beats of the current word are still unaccepted.
  - Never pop while fifo_empty=1; no underflow reliance on the FIFO.
- On a pop:
  - word_reg <= fifo_q; idx <= 0; out_valid <= 1.
  - out_data <= slice 0 (lowest slice, or highest if MSB_FIRST=1).
  - out_last <= 0.
  - beats_left <= RATIO.
- On an accepted non-last beat:
  - idx <= idx+1; out_data <= next slice.
  - out_last <= (idx+1 == RATIO-1).
  - beats_left decrements.
- On an accepted last beat with no pop: out_valid <= 0, out_last <= 0, beats_left <= 0.
- Stall (out_valid=1, out_ready=0): out_data, out_last and beats_left hold. AXI-style stability is required; valid never drops without acceptance.
- Latency:
  - FIFO word visible (fifo_empty falls) to first beat valid: 1 cycle.
  - Throughput with out_ready held at 1: exactly RATIO beats per RATIO cycles; the next pop coincides with the last-beat accept.
- fifo_empty rising mid-word has no effect on the held word.
- sclr mid-word: the held word is discarded, fifo_rdreq is forced to 0 that cycle, and no partial beats follow.
- out_ready is ignored while out_valid=0.

Optional Feature:
- Macro: SCFIFO_UNPACK_STARVE_CNT_EN.
- When defined, adds output starve_cnt (32 bits). It increments on every cycle with out_ready=1 & out_valid=0 & reset inactive, saturates at all-ones, and is cleared by aclr_n and by sclr.
- When undefined, the port and the logic are absent. All other behaviour is identical.

Decomposition:
- Shared package scfifo_pkg:
  - function clog2_beats(RATIO);
  - localparam type for the beat index;
  - slice-select function (word, idx, MSB_FIRST) returning OUT_WIDTH bits.
- One natural sub-module: scfifo_unpack_slice_mux (combinational slice select). It is reused by a future wide-to-narrow M20K drain.
- The control logic stays in the top module.

Test Plan:
- Basic: OUT_WIDTH=8, RATIO=4, MSB_FIRST=0, FIFO holds 0x44332211, out_ready=1.
  - One cycle after fifo_empty=0, beats are 0x11, 0x22, 0x33, 0x44 on consecutive cycles.
  - out_last=1 only with 0x44.
  - fifo_rdreq pulses exactly once.
- Back-to-back: FIFO holds 0x44332211 then 0x88776655, out_ready=1.
  - 8 consecutive valid beats with no gap.
  - The second fifo_rdreq coincides with the accept of 0x44.
- Backpressure: drop out_ready after beat 0x22 for 5 cycles.
  - out_data stays at 0x33, out_valid stays 1, beats_left stays 2, fifo_rdreq stays 0.
  - The sequence resumes intact.
- MSB_FIRST=1 with word 0x44332211: beats are 0x44, 0x33, 0x22, 0x11, with out_last on 0x11.
- Mid-word reset: assert sclr for 1 cycle after beat 0x22.
  - Next cycle out_valid=0 and beats_left=0; fifo_rdreq=0 during sclr.
  - Repeat the scenario with an aclr_n pulse mid-cycle: outputs clear asynchronously, before the next edge.
- With SCFIFO_UNPACK_STARVE_CNT_EN: out_ready=1 and FIFO empty for 10 cycles gives starve_cnt=10; sclr then gives starve_cnt=0.
